// File: rtl/kyber_intt_arbiter.sv
// Round-robin owner of a single kyber_intt engine: grants one requester, streams its
// 32 input words into the engine, returns the 32 results tagged with the owner id.
module kyber_intt_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [128*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   res_valid,
  output logic [127:0]           res_data,
  output logic [ID_W-1:0]        res_id,
  output logic                   res_last,
  output logic                   job_done,
  output logic [ID_W-1:0]        job_id,
  output logic                   intt_start,
  output logic                   intt_valid_in,
  output logic [127:0]           intt_data_in,
  input  logic                   intt_ready_in,
  input  logic [127:0]           intt_data_out,
  input  logic                   intt_valid_out,
  input  logic                   intt_done
);

  // Handshake: an input word moves on a cycle where intt_valid_in and intt_ready_in
  // are both high; results have no backpressure, res_valid marks each word once.

  typedef enum logic [2:0] {IDLE, START, LOAD, DRAIN, WAIT_DONE} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [ID_W-1:0]    id, id_nxt;
  logic [ID_W-1:0]    job_id_nxt;
  logic [NUM_REQ-1:0] grant_nxt;
  logic               busy_nxt, start_nxt, job_done_nxt;
  logic [4:0]         in_cnt, in_cnt_nxt;
  logic [4:0]         out_cnt, out_cnt_nxt;
  logic               beat, finish;
  logic               hi_found;
  logic [ID_W-1:0]    hi_sel, lo_sel, pick;

  // Lowest set request at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_sel = ID_W'(i);
        if (ID_W'(i) >= ptr) begin
          hi_found = 1'b1;
          hi_sel   = ID_W'(i);
        end
      end
    end
    pick = hi_found ? hi_sel : lo_sel;
  end

  always_comb begin
    req_ready     = '0;
    intt_valid_in = 1'b0;
    intt_data_in  = '0;
    if (state == LOAD) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (id == ID_W'(i)) begin
          req_ready[i]  = intt_ready_in;
          intt_valid_in = req_valid[i];
          intt_data_in  = req_data[128*i +: 128];
        end
      end
    end
  end

  assign beat      = intt_valid_in & intt_ready_in;
  assign res_valid = (state == DRAIN) & intt_valid_out;
  assign res_data  = (state == DRAIN) ? intt_data_out : '0;
  assign res_id    = id;
  assign res_last  = res_valid & (out_cnt == 5'd31);
  // An early done while draining is accepted as completion so the engine is never stranded.
  assign finish    = ((state == DRAIN) || (state == WAIT_DONE)) & intt_done;

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    id_nxt       = id;
    grant_nxt    = grant;
    busy_nxt     = busy;
    start_nxt    = 1'b0;
    job_done_nxt = 1'b0;
    job_id_nxt   = job_id;
    in_cnt_nxt   = in_cnt;
    out_cnt_nxt  = out_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          id_nxt    = pick;
          grant_nxt = '0;
          for (int i = 0; i < NUM_REQ; i++) grant_nxt[i] = (pick == ID_W'(i));
          busy_nxt    = 1'b1;
          start_nxt   = 1'b1;
          in_cnt_nxt  = '0;
          out_cnt_nxt = '0;
          state_nxt   = START;
        end
      end
      START: state_nxt = LOAD;
      LOAD: begin
        if (beat) begin
          in_cnt_nxt = in_cnt + 5'd1;
          if (in_cnt == 5'd31) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (res_valid) begin
          out_cnt_nxt = out_cnt + 5'd1;
          if (out_cnt == 5'd31) state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: ;
      default: state_nxt = IDLE;
    endcase
    if (finish) begin
      job_done_nxt = 1'b1;
      job_id_nxt   = id;
      grant_nxt    = '0;
      busy_nxt     = 1'b0;
      ptr_nxt      = (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
      state_nxt    = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      id         <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      intt_start <= 1'b0;
      job_done   <= 1'b0;
      job_id     <= '0;
      in_cnt     <= '0;
      out_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      id         <= id_nxt;
      grant      <= grant_nxt;
      busy       <= busy_nxt;
      intt_start <= start_nxt;
      job_done   <= job_done_nxt;
      job_id     <= job_id_nxt;
      in_cnt     <= in_cnt_nxt;
      out_cnt    <= out_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_kyber_intt_arbiter.sv
// Directed bench for kyber_intt_arbiter with a behavioural engine and a result scoreboard.
module tb_kyber_intt_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int W       = ID_W + 1 + 128;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_REQ-1:0]     req, req_valid, req_ready, grant;
  logic [128*NUM_REQ-1:0] req_data;
  logic                   busy, res_valid, res_last, job_done;
  logic [127:0]           res_data;
  logic [ID_W-1:0]        res_id, job_id;
  logic                   intt_start, intt_valid_in, intt_ready_in, intt_valid_out, intt_done;
  logic [127:0]           intt_data_in, intt_data_out;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  logic [W-1:0]    exp_q[$];
  logic [ID_W-1:0] exp_job_q[$];
  logic [W-1:0]    mon_w;
  logic [ID_W-1:0] mon_id;
  logic [127:0]    job_words[32];

  // clock / reset
  always #5 clk = ~clk;

  kyber_intt_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .grant(grant), .busy(busy), .res_valid(res_valid),
    .res_data(res_data), .res_id(res_id), .res_last(res_last), .job_done(job_done),
    .job_id(job_id), .intt_start(intt_start), .intt_valid_in(intt_valid_in),
    .intt_data_in(intt_data_in), .intt_ready_in(intt_ready_in),
    .intt_data_out(intt_data_out), .intt_valid_out(intt_valid_out), .intt_done(intt_done)
  );

  function automatic logic [127:0] xform(input logic [127:0] w);
    return {w[119:0], w[127:120]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Behavioural engine: load 32 words, short compute, emit transformed words with
  // gaps, one stray valid while waiting for done, then a one-cycle done.
  int          eng_st, eng_cnt, eng_wait, eng_oc;
  logic [127:0] eng_mem[32];
  logic        s_start, s_beat, s_reset;
  logic [127:0] s_data;

  initial begin
    eng_st = 0; eng_cnt = 0; eng_wait = 0; eng_oc = 0;
    intt_ready_in = 1'b0; intt_valid_out = 1'b0; intt_done = 1'b0; intt_data_out = '0;
    forever begin
      @(negedge clk);
      s_start = intt_start; s_beat = intt_valid_in & intt_ready_in;
      s_data = intt_data_in; s_reset = reset;
      @(posedge clk); #1;
      if (s_reset) begin
        eng_st = 0; intt_ready_in = 1'b0; intt_valid_out = 1'b0;
        intt_done = 1'b0; intt_data_out = '0;
      end else begin
        case (eng_st)
          0: begin
            intt_done = 1'b0;
            if (s_start) begin eng_st = 1; intt_ready_in = 1'b1; eng_cnt = 0; end
          end
          1: if (s_beat) begin
            eng_mem[eng_cnt] = s_data;
            eng_cnt++;
            if (eng_cnt == 32) begin intt_ready_in = 1'b0; eng_st = 2; eng_wait = 6; end
          end
          2: begin
            eng_wait--;
            if (eng_wait == 0) begin
              eng_st = 3; eng_cnt = 0; eng_oc = 0;
              intt_valid_out = 1'b1; intt_data_out = xform(eng_mem[0]);
            end
          end
          3: begin
            if (intt_valid_out) eng_cnt++;
            eng_oc++;
            if (eng_cnt == 32) begin
              intt_valid_out = 1'b0; intt_data_out = '0; eng_st = 4; eng_wait = 4;
            end else begin
              intt_valid_out = (eng_oc % 4 != 3);
              intt_data_out  = xform(eng_mem[eng_cnt]);
            end
          end
          4: begin
            eng_wait--;
            intt_valid_out = (eng_wait == 3);
            intt_data_out  = (eng_wait == 3) ? 128'hdead_beef : '0;
            if (eng_wait == 0) begin intt_valid_out = 1'b0; intt_done = 1'b1; eng_st = 5; end
          end
          default: begin intt_done = 1'b0; eng_st = 0; end
        endcase
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (intt_start) start_cnt++;
    if (res_valid) begin
      if (exp_q.size() == 0) chk("res_extra", W'(res_valid), '0);
      else begin
        mon_w = exp_q.pop_front();
        chk("res_word", {res_id, res_last, res_data}, mon_w);
      end
    end
    if (job_done) begin
      if (exp_job_q.size() == 0) chk("done_extra", W'(job_done), '0);
      else begin
        mon_id = exp_job_q.pop_front();
        chk("job_id", W'(job_id), W'(mon_id));
      end
    end
    if (req_ready != '0) chk("ready_owner", W'(req_ready & ~grant), '0);
  end

  // driver tasks
  task automatic stream(input int r, input bit gaps, input int abort_at, output int n);
    int cyc;
    logic bt;
    n = 0; cyc = 0;
    req_valid[r] = 1'b1;
    req_data[128*r +: 128] = job_words[0];
    while (n < 32 && cyc < 300) begin
      @(negedge clk);
      bt = req_valid[r] & req_ready[r];
      @(posedge clk); #1;
      cyc++;
      if (bt) n++;
      if (n == abort_at) break;
      req_valid[r] = (n < 32) && (!gaps || (cyc % 2 == 0));
      if (n < 32) req_data[128*r +: 128] = job_words[n];
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic do_job(input int exp_id, input bit gaps, input int abort_at, input bit ones);
    int n, cyc;
    start_cnt = 0;
    for (int k = 0; k < 32; k++)
      job_words[k] = ones ? {8{16'd1}} : {$urandom(), $urandom(), $urandom(), $urandom()};
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (grant == '0 && cyc < 50);
    chk("grant", W'(grant), W'(4'b0001 << exp_id));
    chk("busy_on", W'(busy), 1);
    chk("start_with_grant", W'(intt_start), 1);
    @(posedge clk); #1;
    req[exp_id] = 1'b0;
    stream(exp_id, gaps, abort_at, n);
    if (abort_at >= 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_grant", W'(grant), 0);
      chk("abort_busy", W'(busy), 0);
      chk("abort_res_valid", W'(res_valid), 0);
      repeat (60) @(negedge clk);
      chk("abort_idle", W'(busy), 0);
      chk("abort_start_pulses", W'(start_cnt), 1);
      return;
    end
    chk("beats", W'(n), 32);
    for (int k = 0; k < 32; k++)
      exp_q.push_back({ID_W'(exp_id), (k == 31), xform(job_words[k])});
    exp_job_q.push_back(ID_W'(exp_id));
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!job_done && cyc < 400);
    chk("job_done_seen", W'(job_done), 1);
    chk("grant_clear", W'(grant), 0);
    chk("busy_clear", W'(busy), 0);
    chk("res_count", W'(exp_q.size()), 0);
    chk("start_pulses", W'(start_cnt), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = '0; req_valid = '0; req_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_grant", W'(grant), 0);
    chk("rst_busy", W'(busy), 0);
    chk("rst_start", W'(intt_start), 0);
    chk("rst_res", {res_valid, res_last, job_done, job_id}, 0);
    chk("rst_ready", {req_ready, intt_valid_in}, 0);

    // single requester, all-ones coefficients
    req = 4'b0001;
    do_job(0, 1'b0, -1, 1'b1);

    // all four at once after pointer reset
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req = 4'b1111;
    for (int j = 0; j < 4; j++) do_job(j, 1'b0, -1, 1'b0);

    // pointer wrap: after id 2, id 0 beats id 2
    req = 4'b0100;
    do_job(2, 1'b0, -1, 1'b0);
    req = 4'b0101;
    do_job(0, 1'b0, -1, 1'b0);
    do_job(2, 1'b0, -1, 1'b0);

    // gapped input stream
    req = 4'b1000;
    do_job(3, 1'b1, -1, 1'b0);

    // reset at input word 10, then a clean job on id 1
    req = 4'b0001;
    do_job(0, 1'b0, 10, 1'b0);
    req = 4'b0010;
    do_job(1, 1'b0, -1, 1'b0);

    // requester 1 again, req dropped right after grant
    req = 4'b0010;
    do_job(1, 1'b0, -1, 1'b0);

    repeat (10) @(negedge clk);
    chk("final_queue", W'(exp_q.size() + exp_job_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kyber_intt_arbiter.md
Name: kyber_intt_arbiter

Overview:
- Round-robin scheduler that shares one kyber_intt engine between NUM_REQ polynomial producers, e.g. the k rows of a Kyber matrix-vector stage.
- Grants one requester at a time and pulses the engine start.
- Streams the granted requester's 32×128-bit words into the engine.
- Returns the engine's 32 output words tagged with the requester id.
- Releases the engine on engine done, then advances the round-robin pointer.

Parameters:
- NUM_REQ, 4: number of requesters (2..4, Kyber k).
- ID_W, 2: width of requester id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset; also drives the engine's reset.
- req  in  NUM_REQ  per-requester job request; level, held until granted.
- req_valid  in  NUM_REQ  per-requester input word valid.
- req_data  in  128*NUM_REQ  per-requester input word; slice i is bits [128*i +: 128], 8×16-bit coefficients, coefficient 0 in the LSBs.
- req_ready  out  NUM_REQ  one-hot word-accept to the granted requester only.
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  high from grant through job completion.
- res_valid  out  1  output word valid; no backpressure.
- res_data  out  128  output word.
- res_id  out  ID_W  owner id of res_data.
- res_last  out  1  high with the 32nd output word.
- job_done  out  1  one-cycle pulse at job completion.
- job_id  out  ID_W  id qualified by job_done.
- intt_start  out  1  to engine start.
- intt_valid_in  out  1  to engine valid_in.
- intt_data_in  out  128  to engine data_in.
- intt_ready_in  in  1  from engine ready_in.
- intt_data_out  in  128  from engine data_out.
- intt_valid_out  in  1  from engine valid_out.
- intt_done  in  1  from engine done.

Behaviour:
- Reset values:
  - grant=0, busy=0, intt_start=0, res_valid=0, res_last=0, job_done=0, job_id=0.
  - State IDLE; round-robin pointer 0; input and output counters 0.
- States: IDLE, START, LOAD, DRAIN, WAIT_DONE.
- IDLE:
  - If any req bit is set, choose the first set bit searching from the pointer upward with wrap.
  - Register grant and id; set busy=1; go to START.
  - req is sampled only in IDLE.
- START: intt_start=1 for exactly this cycle (registered); go to LOAD.
- LOAD:
  - Combinational datapath: intt_valid_in = req_valid[id]; intt_data_in = req_data slice id; req_ready[id] = intt_ready_in.
  - A beat is intt_valid_in & intt_ready_in.
  - The 5-bit in_cnt increments per beat. On the beat with in_cnt==31, go to DRAIN.
  - Gaps in req_valid are legal and only stall.
- Outside LOAD, intt_valid_in=0 and req_ready=0.
- DRAIN:
  - res_valid = intt_valid_out; res_data = intt_data_out; res_id = id. These are combinational, zero added latency.
  - out_cnt increments per valid word; res_last = res_valid & (out_cnt==31).
  - After the 32nd word, go to WAIT_DONE.
  - intt_valid_out outside DRAIN is ignored and res_valid stays 0.
- WAIT_DONE:
  - On intt_done: job_done=1 and job_id=id in the next cycle (registered).
  - Clear grant and busy; pointer = (id+1) mod NUM_REQ; return to IDLE.
  - IDLE may grant again in the cycle after job_done.
- If intt_done arrives in DRAIN (protocol violation), it is treated as WAIT_DONE completion.
- Simultaneous requests: round-robin ordering guarantees no starvation.
- A requester dropping req after grant does not abort its job.
- reset asserted mid-job returns everything to reset values next cycle. No job_done is emitted and the pointer returns to 0.
- Job latency is arbiter overhead of 2 cycles (IDLE→START→LOAD) plus engine time of about 32 load + 1792 compute + 256 scale + 32 output + 1 done.

Test Plan:
- req=0001, 32 back-to-back words of coefficient value 1 → grant=0001, intt_start pulses once, 32 res words with res_id=0, res_last on word 32, job_done with job_id=0, then grant=0000.
- req=1111 at once → jobs granted in order 0,1,2,3; each job_done job_id matches; no overlap of grants.
- After job on id 2, req=0101 → next grant is id 0 (pointer=3 wraps), then id 2.
- req_valid toggled 1,0,1,0 during LOAD → exactly 32 beats accepted, in_cnt stalls on gaps, engine output equals the gap-free run.
- reset pulsed at input word 10 → grant=0, busy=0, no job_done. A new req=0010 afterwards completes normally with job_id=1.
- req[1] dropped the cycle after grant → job still completes, 32 words tagged res_id=1.
